issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL take parameter DEPTH, default 3: pipeline stages from issue to register writeback, legal 2..8.
REQ-002 SHALL take parameter FWD, default 0: 0 = stall until writeback completes, 1 = writeback-stage forwarding enabled.
REQ-003 SHALL take parameter FLUSH_N, default 2: youngest in-flight entries killed by flush, legal 1..DEPTH-1.
REQ-004 SHALL take parameter RA_W, default 5: register address width; NREG = 2**RA_W.
REQ-005 clk  in  1  single clock, all state on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 dec_valid  in  1  decoded instruction present.
REQ-008 dec_rs1, dec_rs2  in  RA_W each  source register addresses.
REQ-009 dec_use1, dec_use2  in  1 each  instruction reads rs1 / rs2.
REQ-010 dec_rd  in  RA_W  destination register; dec_we  in  1  instruction writes rd.
REQ-011 flush  in  1  taken branch/jump resolved this cycle.
REQ-012 issue  out  1  instruction enters pipeline this cycle.
REQ-013 stall  out  1  dec_valid held by hazard; fetch/decode SHALL hold.
REQ-014 wb_valid, wb_we  out  1 each; wb_rd  out  RA_W  writeback-stage entry.
REQ-015 fwd1, fwd2  out  1 each  source taken from writeback data, not regfile.
REQ-016 busy  out  NREG  per-register pending-write bits.
REQ-017 stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-018 SHALL hold DEPTH entries {valid, we, rd}; entry 0 youngest, entry DEPTH-1 is writeback.
REQ-019 Every cycle entries SHALL shift one position; entry DEPTH-1 retires; entry 0 loads {issue, dec_we, dec_rd}, else a bubble.
REQ-020 Entry k SHALL match source s when valid & we & rd==s & s!=0 & use bit set.
REQ-021 FWD=0: any match in entries 0..DEPTH-1 SHALL be a hazard.
REQ-022 FWD=1: match only in entry DEPTH-1 and no younger entry SHALL not be a hazard and SHALL assert the corresponding fwd bit combinationally; younger match SHALL be a hazard.
REQ-023 stall = dec_valid & hazard & ~flush; issue = dec_valid & ~hazard & ~flush; both combinational from current state and inputs.
REQ-024 flush SHALL clear valid of entries 0..FLUSH_N-1 after shifting, and the incoming decode SHALL become a bubble (issue=0, stall=0).
REQ-025 Writes to x0 (dec_rd==0) SHALL enter pipeline with we forced 0.
REQ-026 busy[r] SHALL be OR over entries of (valid & we & rd==r); busy[0] SHALL always be 0.
REQ-027 wb_valid/wb_we/wb_rd SHALL be entry DEPTH-1 fields, registered, zero latency beyond shift.
REQ-028 stall_cnt SHALL increment on each stall cycle, saturate at 0xFFFFFFFF, never wrap.
REQ-029 Two in-flight writes to the same rd SHALL both be tracked; hazard persists until the youngest retires.
REQ-030 Back-to-back independent instructions SHALL issue every cycle (throughput 1).
REQ-031 Worst-case stall for a dependent pair SHALL be DEPTH cycles (FWD=0) or DEPTH-1 (FWD=1).

Reset
REQ-032 rst SHALL immediately clear all entry valid bits and stall_cnt, regardless of clk.
REQ-033 During and after reset: issue, stall, wb_valid, wb_we, fwd1, fwd2 = 0, wb_rd = 0, busy = 0.
REQ-034 Reset mid-operation SHALL discard all in-flight entries; no writeback emitted after release.

Structure
REQ-035 Shared package SHALL hold the entry record type {valid, we, rd}, RA_W default and parameter legality checks.
REQ-036 One sub-module sb_match (one source vs all entries, returns hazard and fwd) SHALL be instantiated twice.

Verification
REQ-037 DEPTH=3, FWD=0: issue rd=5, next cycle rs1=5 -> stall 3 cycles, issue on 4th, stall_cnt=3.
REQ-038 DEPTH=3, FWD=1: same sequence -> stall 2 cycles, issue with fwd1=1 on 3rd.
REQ-039 rd=0 producer then rs1=0 consumer -> no stall, busy=0.
REQ-040 rd=7 issued, flush next cycle (FLUSH_N=2) -> busy[7]=0, no wb_valid for it, decode that cycle dropped.
REQ-041 Assert rst with 3 valid entries between clock edges -> outputs zero before next edge; after release wb_valid stays 0 for DEPTH cycles.
REQ-042 Force 2**32+5 stall cycles (or preload via hierarchical force) -> stall_cnt holds 0xFFFFFFFF.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// issue_scoreboard_pkg
// Purpose : shared types, constants and parameter legality checks for the
//           in-order issue scoreboard.
// Contents: RA_W_DEFAULT   default register-address width
//           RA_W_MAX       widest register address an entry can hold
//           sb_entry_t     one in-flight pipeline entry {valid, we, rd}
//           sb_params_legal  elaboration-time parameter check
// ---------------------------------------------------------------------------
package issue_scoreboard_pkg;

    localparam int RA_W_DEFAULT = 5;
    localparam int RA_W_MAX     = 8;

    // rd is stored at the widest supported width so one record type serves
    // every RA_W; narrower addresses are zero-extended on entry.
    typedef struct packed {
        logic                valid;
        logic                we;
        logic [RA_W_MAX-1:0] rd;
    } sb_entry_t;

    function automatic bit sb_params_legal(int depth, int fwd, int flush_n, int ra_w);
        return (depth >= 2) && (depth <= 8) &&
               ((fwd == 0) || (fwd == 1)) &&
               (flush_n >= 1) && (flush_n <= depth - 1) &&
               (ra_w >= 1) && (ra_w <= RA_W_MAX);
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// ---------------------------------------------------------------------------
// issue_scoreboard_if
// Purpose : bundles the decode-side request, the issue/stall response and the
//           writeback/status outputs of the issue scoreboard.
// Modports: master - decode/fetch side (drives dec_*, flush)
//           slave  - the scoreboard (drives issue, stall, wb_*, fwd*, busy,
//                    stall_cnt)
// ---------------------------------------------------------------------------
interface issue_scoreboard_if
    import issue_scoreboard_pkg::*;
#(
    parameter int RA_W = RA_W_DEFAULT
);
    localparam int NREG = 2 ** RA_W;

    logic            dec_valid;
    logic [RA_W-1:0] dec_rs1;
    logic [RA_W-1:0] dec_rs2;
    logic            dec_use1;
    logic            dec_use2;
    logic [RA_W-1:0] dec_rd;
    logic            dec_we;
    logic            flush;

    logic            issue;
    logic            stall;
    logic            wb_valid;
    logic            wb_we;
    logic [RA_W-1:0] wb_rd;
    logic            fwd1;
    logic            fwd2;
    logic [NREG-1:0] busy;
    logic [31:0]     stall_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use1, dec_use2, dec_rd, dec_we, flush,
        input  issue, stall, wb_valid, wb_we, wb_rd, fwd1, fwd2, busy, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use1, dec_use2, dec_rd, dec_we, flush,
        output issue, stall, wb_valid, wb_we, wb_rd, fwd1, fwd2, busy, stall_cnt
    );

endinterface

// File: rtl/issue_scoreboard_sb_match.sv
// ---------------------------------------------------------------------------
// sb_match
// Purpose : compares one source register against every in-flight entry and
//           decides whether the reading instruction must wait.
// Ports   : i_entries  in   DEPTH entries, index DEPTH-1 is writeback
//           i_src      in   source register address
//           i_use      in   instruction actually reads i_src
//           o_hazard   out  source not yet available
//           o_fwd      out  source must come from the writeback stage
// ---------------------------------------------------------------------------
module sb_match
    import issue_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int FWD   = 0,
    parameter int RA_W  = RA_W_DEFAULT
)
(
    input  sb_entry_t [DEPTH-1:0] i_entries,
    input  logic [RA_W-1:0]       i_src,
    input  logic                  i_use,
    output logic                  o_hazard,
    output logic                  o_fwd
);

    logic [DEPTH-1:0]    w_match;
    logic [RA_W_MAX-1:0] w_src_ext;

    assign w_src_ext = RA_W_MAX'(i_src);

    // x0 is hard-wired zero, so a read of it never depends on anything.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_match[k] = i_entries[k].valid & i_entries[k].we &
                         (i_entries[k].rd == w_src_ext) &
                         (i_src != '0) & i_use;
        end
    end

    // With forwarding, a producer sitting in writeback can feed the reader
    // directly, but only if no younger in-flight write to the same register
    // would supersede it.
    generate
        if (FWD != 0) begin : g_fwd
            logic w_young;
            assign w_young  = |w_match[DEPTH-2:0];
            assign o_hazard = w_young;
            assign o_fwd    = w_match[DEPTH-1] & ~w_young;
        end else begin : g_nofwd
            assign o_hazard = |w_match;
            assign o_fwd    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/issue_scoreboard.sv
// ---------------------------------------------------------------------------
// issue_scoreboard
// Purpose : in-order issue scoreboard. Tracks DEPTH in-flight writes in a
//           shift pipeline, stalls decode on read-after-write hazards,
//           optionally forwards from writeback, supports branch flush.
// Ports   : clk   in  single clock, all state on posedge
//           rst   in  asynchronous active-high reset
//           sb    issue_scoreboard_if.slave
//                     dec_*  decoded instruction, flush  branch resolved
//                     issue/stall  decode handshake, fwd1/fwd2  bypass select
//                     wb_*   writeback-stage entry, busy  pending writes
//                     stall_cnt  saturating stall-cycle counter
// ---------------------------------------------------------------------------
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int FWD     = 0,
    parameter int FLUSH_N = 2,
    parameter int RA_W    = RA_W_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    issue_scoreboard_if.slave sb
);

    localparam int NREG = 2 ** RA_W;

    generate
        if (!sb_params_legal(DEPTH, FWD, FLUSH_N, RA_W)) begin : g_bad_params
            $error("issue_scoreboard: illegal DEPTH/FWD/FLUSH_N/RA_W combination");
        end
    endgenerate

    sb_entry_t [DEPTH-1:0] r_entries;
    logic [31:0]           r_stall_cnt;

    logic                  w_haz1;
    logic                  w_haz2;
    logic                  w_fwd1;
    logic                  w_fwd2;
    logic                  w_hazard;
    logic                  w_issue;
    logic                  w_stall;
    sb_entry_t             w_new_entry;
    logic [NREG-1:0]       w_busy;

    sb_match #(.DEPTH(DEPTH), .FWD(FWD), .RA_W(RA_W)) u_match1 (
        .i_entries (r_entries),
        .i_src     (sb.dec_rs1),
        .i_use     (sb.dec_use1),
        .o_hazard  (w_haz1),
        .o_fwd     (w_fwd1)
    );

    sb_match #(.DEPTH(DEPTH), .FWD(FWD), .RA_W(RA_W)) u_match2 (
        .i_entries (r_entries),
        .i_src     (sb.dec_rs2),
        .i_use     (sb.dec_use2),
        .o_hazard  (w_haz2),
        .o_fwd     (w_fwd2)
    );

    // Flush turns the current decode into a bubble, so it neither issues nor
    // counts as a stall; reset gates both so nothing appears to issue while
    // the pipeline is being cleared.
    assign w_hazard = w_haz1 | w_haz2;
    assign w_issue  = sb.dec_valid & ~w_hazard & ~sb.flush & ~rst;
    assign w_stall  = sb.dec_valid &  w_hazard & ~sb.flush & ~rst;

    // Bubbles load as all-zero so writeback fields are quiet when not valid;
    // x0 destinations never count as a pending write.
    always_comb begin
        w_new_entry = '0;
        if (w_issue) begin
            w_new_entry.valid = 1'b1;
            w_new_entry.we    = sb.dec_we & (sb.dec_rd != '0);
            w_new_entry.rd    = RA_W_MAX'(sb.dec_rd);
        end
    end

    // The pipeline shifts every cycle; after the shift the FLUSH_N youngest
    // slots are wiped on flush (slot 0 is already a bubble then).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entries <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                if (sb.flush && (k < FLUSH_N)) begin
                    r_entries[k] <= '0;
                end else begin
                    r_entries[k] <= r_entries[k-1];
                end
            end
            r_entries[0] <= w_new_entry;
        end
    end

    // Counter stops at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    always_comb begin
        w_busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_entries[k].valid && r_entries[k].we) begin
                w_busy[r_entries[k].rd[RA_W-1:0]] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
    end

    assign sb.issue     = w_issue;
    assign sb.stall     = w_stall;
    assign sb.fwd1      = w_fwd1;
    assign sb.fwd2      = w_fwd2;
    assign sb.wb_valid  = r_entries[DEPTH-1].valid;
    assign sb.wb_we     = r_entries[DEPTH-1].we;
    assign sb.wb_rd     = r_entries[DEPTH-1].rd[RA_W-1:0];
    assign sb.busy      = w_busy;
    assign sb.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_issue_scoreboard
// Purpose : drives two scoreboards (DEPTH=3, FLUSH_N=2, one without and one
//           with writeback forwarding) with directed instruction sequences.
//           Stimulus pushes the expected issue cycle / bypass bits and the
//           expected writeback into queues; a monitor pops them whenever the
//           selected DUT issues or writes back.
// ---------------------------------------------------------------------------
module tb_issue_scoreboard;

    localparam int DEPTH = 3;

    typedef struct {
        int   cyc;
        logic fwd1;
        logic fwd2;
    } issExp_t;

    typedef struct {
        int         cyc;
        logic       we;
        logic [4:0] rd;
    } wbExp_t;

    logic       clk;
    logic       rst;
    logic       dv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       we;
    logic       fl;
    bit         sel;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    issExp_t    issQ[$];
    wbExp_t     wbQ[$];

    issue_scoreboard_if #(.RA_W(5)) if0 ();
    issue_scoreboard_if #(.RA_W(5)) if1 ();

    assign if0.dec_valid = dv;
    assign if0.dec_rs1   = rs1;
    assign if0.dec_rs2   = rs2;
    assign if0.dec_use1  = use1;
    assign if0.dec_use2  = use2;
    assign if0.dec_rd    = rd;
    assign if0.dec_we    = we;
    assign if0.flush     = fl;

    assign if1.dec_valid = dv;
    assign if1.dec_rs1   = rs1;
    assign if1.dec_rs2   = rs2;
    assign if1.dec_use1  = use1;
    assign if1.dec_use2  = use2;
    assign if1.dec_rd    = rd;
    assign if1.dec_we    = we;
    assign if1.flush     = fl;

    issue_scoreboard #(.DEPTH(DEPTH), .FWD(0), .FLUSH_N(2), .RA_W(5)) dut0 (
        .clk (clk),
        .rst (rst),
        .sb  (if0)
    );

    issue_scoreboard #(.DEPTH(DEPTH), .FWD(1), .FLUSH_N(2), .RA_W(5)) dut1 (
        .clk (clk),
        .rst (rst),
        .sb  (if1)
    );

    // Observation point follows whichever DUT the current phase exercises.
    logic        mIssue, mStall, mFwd1, mFwd2, mWbValid, mWbWe;
    logic [4:0]  mWbRd;
    logic [31:0] mBusy, mCnt;

    assign mIssue   = sel ? if1.issue     : if0.issue;
    assign mStall   = sel ? if1.stall     : if0.stall;
    assign mFwd1    = sel ? if1.fwd1      : if0.fwd1;
    assign mFwd2    = sel ? if1.fwd2      : if0.fwd2;
    assign mWbValid = sel ? if1.wb_valid  : if0.wb_valid;
    assign mWbWe    = sel ? if1.wb_we     : if0.wb_we;
    assign mWbRd    = sel ? if1.wb_rd     : if0.wb_rd;
    assign mBusy    = sel ? if1.busy      : if0.busy;
    assign mCnt     = sel ? if1.stall_cnt : if0.stall_cnt;

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index advances on every active edge; stimulus reads it just
    // after the edge and the monitor reads it at the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something never returns.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every issue and every writeback of the selected DUT
    // must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        issExp_t ie;
        wbExp_t  wexp;
        if (mIssue) begin
            checkOutput("issueExpected", 32'(issQ.size() != 0), 32'd1);
            if (issQ.size() != 0) begin
                ie = issQ.pop_front();
                checkOutput("issueCycle", cyc, ie.cyc);
                checkOutput("issueFwd1", 32'(mFwd1), 32'(ie.fwd1));
                checkOutput("issueFwd2", 32'(mFwd2), 32'(ie.fwd2));
            end
        end
        if (mWbValid) begin
            checkOutput("wbExpected", 32'(wbQ.size() != 0), 32'd1);
            if (wbQ.size() != 0) begin
                wexp = wbQ.pop_front();
                checkOutput("wbCycle", cyc, wexp.cyc);
                checkOutput("wbWe", 32'(mWbWe), 32'(wexp.we));
                checkOutput("wbRd", 32'(mWbRd), 32'(wexp.rd));
            end
        end
    end

    // Drive one instruction from the start of a cycle, record what should
    // happen, then hold it until it issues (bounded) and count stall cycles.
    task automatic applyStimulus(input logic [4:0] r1, input logic u1,
                                 input logic [4:0] r2, input logic u2,
                                 input logic [4:0] rdx, input logic wex,
                                 input int expStall, input logic eF1,
                                 input logic eF2, input bit survives);
        issExp_t ie;
        wbExp_t  wexp;
        int      nStall;
        int      waited;
        bit      seen;
        nStall = 0;
        waited = 0;
        seen   = 0;
        dv = 1'b1; rs1 = r1; use1 = u1; rs2 = r2; use2 = u2; rd = rdx; we = wex; fl = 1'b0;
        ie.cyc  = cyc + expStall;
        ie.fwd1 = eF1;
        ie.fwd2 = eF2;
        issQ.push_back(ie);
        if (survives) begin
            wexp.cyc = cyc + expStall + DEPTH;
            wexp.we  = wex && (rdx != 5'd0);
            wexp.rd  = rdx;
            wbQ.push_back(wexp);
        end
        while (!seen && (waited <= expStall + 4)) begin
            @(negedge clk);
            if (mIssue) begin
                seen = 1;
            end else begin
                if (mStall) nStall++;
                @(posedge clk); #1;
            end
            waited++;
        end
        checkOutput("issued", 32'(seen), 32'd1);
        checkOutput("stallCycles", nStall, expStall);
        @(posedge clk); #1;
        dv = 1'b0; use1 = 1'b0; use2 = 1'b0;
    endtask

    task automatic idle(input int n);
        dv = 1'b0; use1 = 1'b0; use2 = 1'b0; fl = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Directed sequence: reset, hazards, throughput, x0, double writes,
    // flush, asynchronous reset, saturation, then the forwarding variant.
    initial begin
        sel = 1'b0;
        rst = 1'b1;
        dv = 1'b1; rs1 = 5'd0; rs2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
        rd = 5'd5; we = 1'b1; fl = 1'b0;
        #12;
        checkOutput("rstIssue", 32'(mIssue), 32'd0);
        checkOutput("rstStall", 32'(mStall), 32'd0);
        checkOutput("rstWbValid", 32'(mWbValid), 32'd0);
        checkOutput("rstWbWe", 32'(mWbWe), 32'd0);
        checkOutput("rstWbRd", 32'(mWbRd), 32'd0);
        checkOutput("rstFwd1", 32'(mFwd1), 32'd0);
        checkOutput("rstBusy", mBusy, 32'd0);
        checkOutput("rstCnt", mCnt, 32'd0);
        dv = 1'b0;
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Dependent pair without forwarding: three stall cycles.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3, 1'b0, 1'b0, 1'b1);
        checkOutput("depPairCnt", mCnt, 32'd3);

        // Independent instructions issue every cycle.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(5'd9, 1'b1, 5'd0, 1'b0, 5'(i), 1'b1, 0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("streamBusy", mBusy, 32'h0000_001C);
        idle(4);
        checkOutput("drainedBusy", mBusy, 32'd0);

        // x0 producer and consumer never interact.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        checkOutput("x0Busy", mBusy, 32'd0);

        // Two writes to r7 in flight: reader on rs2 waits for the younger.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b0, 3, 1'b0, 1'b0, 1'b1);
        idle(4);

        // Flush: r10 retires, r11 survives in writeback, r7 is killed and the
        // hazarding decode of the flush cycle is dropped.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        dv = 1'b1; rs1 = 5'd7; use1 = 1'b1; rd = 5'd9; we = 1'b1; fl = 1'b1;
        #1;
        checkOutput("flushIssue", 32'(mIssue), 32'd0);
        checkOutput("flushStall", 32'(mStall), 32'd0);
        @(posedge clk); #1;
        fl = 1'b0; dv = 1'b0; use1 = 1'b0;
        checkOutput("flushBusy", mBusy, 32'h0000_0800);
        checkOutput("flushBusy7", 32'(mBusy[7]), 32'd0);
        idle(4);

        // Asynchronous reset with three live entries.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("preRstBusy", mBusy, 32'h0000_000E);
        checkOutput("preRstWbRd", 32'(mWbRd), 32'd1);
        #2;
        rst = 1'b1; dv = 1'b1; rd = 5'd4;
        #1;
        checkOutput("midRstWbValid", 32'(mWbValid), 32'd0);
        checkOutput("midRstWbWe", 32'(mWbWe), 32'd0);
        checkOutput("midRstWbRd", 32'(mWbRd), 32'd0);
        checkOutput("midRstBusy", mBusy, 32'd0);
        checkOutput("midRstCnt", mCnt, 32'd0);
        checkOutput("midRstIssue", 32'(mIssue), 32'd0);
        rst = 1'b0; dv = 1'b0;
        repeat (DEPTH + 1) begin
            @(negedge clk);
            checkOutput("postRstWbValid", 32'(mWbValid), 32'd0);
        end
        @(posedge clk); #1;

        // Saturation: preload near the top, then add stalls.
        force dut0.r_stall_cnt = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        release dut0.r_stall_cnt;
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 3, 1'b0, 1'b0, 1'b1);
        checkOutput("satCnt1", mCnt, 32'hFFFF_FFFF);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 3, 1'b0, 1'b0, 1'b1);
        checkOutput("satCnt2", mCnt, 32'hFFFF_FFFF);
        idle(6);

        // Forwarding variant.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        sel = 1'b1;
        @(posedge clk); #1;
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 2, 1'b1, 1'b0, 1'b1);
        checkOutput("fwdPairCnt", mCnt, 32'd2);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd6, 1'b0, 5'd6, 1'b1, 5'd9, 1'b0, 2, 1'b0, 1'b1, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 2, 1'b1, 1'b0, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(1);
        applyStimulus(5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1, 1'b1, 1'b0, 1'b1);
        checkOutput("fwdTotalCnt", mCnt, 32'd7);
        idle(DEPTH + 3);

        checkOutput("issQLeftover", issQ.size(), 32'd0);
        checkOutput("wbQLeftover", wbQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
